// File: rtl/pipeline_hazard_ctrl_pkg.sv
// hazard_pkg: shared state encodings and register-index constants for the hazard controller
package hazard_pkg;
  localparam int DEF_REG_ADDR_W = 5;
  localparam logic [4:0] X0 = 5'd0;
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR      = 2'd2;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-side status and register-control bundle (perf outputs under HAZARD_PERF_EN)
interface pipeline_hazard_ctrl_if #(parameter int REG_ADDR_W = 5);
  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic                  id_use_rs2_i;
  logic                  ex_memread_i;
  logic [REG_ADDR_W-1:0] ex_rd_i;
  logic                  branch_taken_i;
  logic                  mem_req_i;
  logic                  mem_ready_i;
  logic                  pc_we_o;
  logic                  if_id_we_o;
  logic                  if_id_flush_o;
  logic                  id_ex_we_o;
  logic                  id_ex_bubble_o;
  logic                  ex_mem_we_o;
  logic                  mem_err_o;
  logic [1:0]            state_o;
`ifdef HAZARD_PERF_EN
  logic [31:0]           perf_stall_o;
  logic [31:0]           perf_flush_o;
`endif
  modport master (
    input  id_rs1_i, id_rs2_i, id_use_rs2_i, ex_memread_i, ex_rd_i,
           branch_taken_i, mem_req_i, mem_ready_i,
    output pc_we_o, if_id_we_o, if_id_flush_o, id_ex_we_o, id_ex_bubble_o,
           ex_mem_we_o, mem_err_o, state_o
`ifdef HAZARD_PERF_EN
    , output perf_stall_o, perf_flush_o
`endif
  );
  modport slave (
    output id_rs1_i, id_rs2_i, id_use_rs2_i, ex_memread_i, ex_rd_i,
           branch_taken_i, mem_req_i, mem_ready_i,
    input  pc_we_o, if_id_we_o, if_id_flush_o, id_ex_we_o, id_ex_bubble_o,
           ex_mem_we_o, mem_err_o, state_o
`ifdef HAZARD_PERF_EN
    , input perf_stall_o, perf_flush_o
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_lu_detect.sv
// hazard_lu_detect: flags an ID instruction reading the destination of a load still in EX
module hazard_lu_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs2,
  output logic                  lu
);
  // x0 never carries a real dependency
  always_comb
    lu = ex_memread & (ex_rd != REG_ADDR_W'(X0)) &
         ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for PC, IF/ID, ID/EX, EX/MEM; HAZARD_PERF_EN adds stall/flush counters
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input logic clk_i,
  input logic rst_i,
  pipeline_hazard_ctrl_if.master bus
);
  logic [1:0]       state, state_nx;
  logic [TMO_W-1:0] cnt, cnt_nx;
  logic             err, err_nx;
  logic             lu, stall, go;

  hazard_lu_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
    .ex_memread (bus.ex_memread_i),
    .ex_rd      (bus.ex_rd_i),
    .id_rs1     (bus.id_rs1_i),
    .id_rs2     (bus.id_rs2_i),
    .id_use_rs2 (bus.id_use_rs2_i),
    .lu         (lu)
  );

  // memory stall dominates; a MEM_WAIT cycle with ready behaves as a normal RUN cycle
  always_comb begin
    stall = (state == ST_RUN)      ? (bus.mem_req_i & ~bus.mem_ready_i) :
            (state == ST_MEM_WAIT) ? ~bus.mem_ready_i : 1'b1;
    go = rst_i & ~stall;
    bus.pc_we_o        = go & ~lu;
    bus.if_id_we_o     = go & ~lu;
    bus.if_id_flush_o  = ~rst_i | (go & ~lu & bus.branch_taken_i);
    bus.id_ex_we_o     = go;
    bus.id_ex_bubble_o = ~rst_i | (go & lu);
    bus.ex_mem_we_o    = go;
    bus.mem_err_o      = err;
    bus.state_o        = state;
  end

  // next state, saturating wait counter and sticky timeout flag
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = err;
    if (state == ST_RUN) begin
      if (stall) begin
        state_nx = ST_MEM_WAIT;
        cnt_nx   = TMO_W'(1);
      end
    end else if (state == ST_MEM_WAIT) begin
      if (bus.mem_ready_i) begin
        state_nx = ST_RUN;
        cnt_nx   = '0;
      end else if (cnt >= TMO_W'(MEM_TIMEOUT - 1)) begin
        state_nx = ST_ERR;
        cnt_nx   = TMO_W'(MEM_TIMEOUT);
        err_nx   = 1'b1;
      end else begin
        cnt_nx = cnt + TMO_W'(1);
      end
    end else begin
      state_nx = ST_ERR;
      err_nx   = 1'b1;
    end
  end

  // control state registers
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= ST_RUN;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err   <= err_nx;
    end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall, perf_flush;

  // saturating counts of frozen-PC and flush cycles
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (!bus.pc_we_o && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
      if (bus.if_id_flush_o && perf_flush != '1) perf_flush <= perf_flush + 32'd1;
    end

  // expose the counters
  always_comb begin
    bus.perf_stall_o = perf_stall;
    bus.perf_flush_o = perf_flush;
  end
`endif
endmodule
